// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB master port between NUM_REQ command requesters.
// Define APB_ARB_TIMEOUT_EN to abort an ACCESS phase after TIMEOUT_CYC cycles without pready_i.
module apb_rr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ-1:0]        req_write_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      err_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic [ADDR_W-1:0]         paddr_o,
  output logic                      pwrite_o,
  output logic [DATA_W-1:0]         pwdata_o,
  input  logic                      pready_i,
  input  logic [DATA_W-1:0]         prdata_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("apb_rr_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC at least 1");
  end

  logic [1:0]         r_state;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   r_owner;
  logic [ADDR_W-1:0]  r_paddr;
  logic               r_pwrite;
  logic [DATA_W-1:0]  r_pwdata;
  logic [DATA_W-1:0]  r_rdata;
  logic [NUM_REQ-1:0] r_done;

  logic               w_found;
  logic [IDX_W-1:0]   w_winner;
  logic [IDX_W-1:0]   w_scan_idx;
  logic               w_grant;
  logic               w_complete;
  logic               w_abort;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic               w_sel_write;
  logic [DATA_W-1:0]  w_sel_wdata;

  // Scan starts just after the last owner, so the most recent winner gets lowest priority.
  always_comb begin
    w_found    = 1'b0;
    w_winner   = r_last;
    w_scan_idx = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_scan_idx = IDX_W'((int'(r_last) + off) % NUM_REQ);
      if (!w_found && req_i[w_scan_idx]) begin
        w_found  = 1'b1;
        w_winner = w_scan_idx;
      end
    end
  end

  always_comb begin
    w_sel_addr  = '0;
    w_sel_write = 1'b0;
    w_sel_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_winner == IDX_W'(k)) begin
        w_sel_addr  = req_addr_i[k*ADDR_W +: ADDR_W];
        w_sel_write = req_write_i[k];
        w_sel_wdata = req_wdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // Grant is combinational; gating with reset keeps every output low while reset is held.
  assign w_grant    = (r_state == ST_IDLE) && w_found && !reset;
  assign w_complete = (r_state == ST_ACCESS) && pready_i;

  always_comb begin
    gnt_o = '0;
    if (w_grant) gnt_o[w_winner] = 1'b1;
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [TCNT_W-1:0] r_tcnt;
  logic              r_err;

  // Held at zero outside ACCESS, so it always starts from zero on entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     r_tcnt <= '0;
    else if (r_state != ST_ACCESS) r_tcnt <= '0;
    else if (!pready_i)            r_tcnt <= r_tcnt + 1'b1;
  end

  assign w_abort = (r_state == ST_ACCESS) && !pready_i &&
                   (r_tcnt == TCNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_err <= 1'b0;
    else       r_err <= w_abort;
  end

  assign err_o = r_err;
`else
  assign w_abort = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_last   <= IDX_W'(NUM_REQ - 1);
      r_owner  <= '0;
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_rdata  <= '0;
      r_done   <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state  <= ST_SETUP;
            r_owner  <= w_winner;
            r_last   <= w_winner;
            r_paddr  <= w_sel_addr;
            r_pwrite <= w_sel_write;
            r_pwdata <= w_sel_wdata;
          end
        end
        ST_SETUP: r_state <= ST_ACCESS;
        ST_ACCESS: begin
          if (w_complete || w_abort) begin
            r_state         <= ST_IDLE;
            r_done[r_owner] <= 1'b1;
            if (w_complete && !r_pwrite) r_rdata <= prdata_i;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign psel_o    = (r_state != ST_IDLE);
  assign penable_o = (r_state == ST_ACCESS);
  assign paddr_o   = r_paddr;
  assign pwrite_o  = r_pwrite;
  assign pwdata_o  = r_pwdata;
  assign rdata_o   = r_rdata;
  assign done_o    = r_done;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Self-checking bench for apb_rr_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of arbitration and APB timing.
module tb_apb_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TO_CYC  = 16;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ-1:0]        req_write_i;
  logic [NUM_REQ*DATA_W-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic [NUM_REQ-1:0]        done_o;
  logic [DATA_W-1:0]         rdata_o;
  logic                      err_o;
  logic                      psel_o;
  logic                      penable_o;
  logic [ADDR_W-1:0]         paddr_o;
  logic                      pwrite_o;
  logic [DATA_W-1:0]         pwdata_o;
  logic                      pready_i;
  logic [DATA_W-1:0]         prdata_i;

  logic [ADDR_W-1:0]  addr_a  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_a [NUM_REQ];
  logic [NUM_REQ-1:0] wr_a;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  apb_rr_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk), .reset(reset),
    .req_i(req_i), .req_addr_i(req_addr_i), .req_write_i(req_write_i), .req_wdata_i(req_wdata_i),
    .gnt_o(gnt_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
    .psel_o(psel_o), .penable_o(penable_o), .paddr_o(paddr_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .pready_i(pready_i), .prdata_i(prdata_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_payload();
    for (int k = 0; k < NUM_REQ; k++) begin
      req_addr_i[k*ADDR_W +: ADDR_W]  = addr_a[k];
      req_wdata_i[k*DATA_W +: DATA_W] = wdata_a[k];
    end
    req_write_i = wr_a;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    req_i    = '0;
    pready_i = 1'b0;
    prdata_i = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    req_i    = '1;
    pready_i = 1'b1;
    prdata_i = 32'hFFFF_FFFF;
    for (int k = 0; k < NUM_REQ; k++) begin
      addr_a[k] = 32'hA5A5_0000 + k; wdata_a[k] = 32'h1111_0000 + k;
    end
    wr_a = '1;
    drive_payload();
    tick();
    @(negedge clk);
    chk_cnt++;
    if ({gnt_o, done_o, psel_o, penable_o, err_o} !== '0)
      $display("FAIL reset_ctrl got gnt=%b done=%b psel=%b pen=%b err=%b, need all 0",
               gnt_o, done_o, psel_o, penable_o, err_o);
    else pass_cnt++;
    chk_cnt++;
    if ({paddr_o, pwrite_o, pwdata_o, rdata_o} !== '0)
      $display("FAIL reset_data got paddr=%h pwrite=%b pwdata=%h rdata=%h, need all 0",
               paddr_o, pwrite_o, pwdata_o, rdata_o);
    else pass_cnt++;
  endtask

  task automatic test_read_zero_wait();
    do_reset();
    addr_a[0] = 32'hDEAD_CAFE; wr_a = 4'b0000; drive_payload();
    prdata_i = 32'h0000_1234; pready_i = 1'b1; req_i = 4'b0001;
    @(negedge clk);
    chk_cnt++;
    if (gnt_o !== 4'b0001 || psel_o !== 1'b0)
      $display("FAIL rd_gnt got gnt=%b psel=%b, need 0001/0", gnt_o, psel_o);
    else pass_cnt++;
    tick(); req_i = '0;
    @(negedge clk);
    chk_cnt++;
    if ({psel_o, penable_o} !== 2'b10 || paddr_o !== 32'hDEAD_CAFE || pwrite_o !== 1'b0)
      $display("FAIL rd_setup got psel/pen=%b%b paddr=%h pwrite=%b, need 10 DEADCAFE 0",
               psel_o, penable_o, paddr_o, pwrite_o);
    else pass_cnt++;
    tick();
    @(negedge clk);
    chk_cnt++;
    if ({psel_o, penable_o} !== 2'b11 || done_o !== '0)
      $display("FAIL rd_access got psel/pen=%b%b done=%b, need 11 0000", psel_o, penable_o, done_o);
    else pass_cnt++;
    tick(); prdata_i = 32'hBAD0_BAD0;
    @(negedge clk);
    chk_cnt++;
    if (done_o !== 4'b0001 || err_o !== 1'b0 || rdata_o !== 32'h0000_1234 || psel_o !== 1'b0)
      $display("FAIL rd_done got done=%b err=%b rdata=%h psel=%b, need 0001 0 00001234 0",
               done_o, err_o, rdata_o, psel_o);
    else pass_cnt++;
  endtask

  // Runs straight after the read so rdata_o holds a known non-zero value.
  task automatic test_write_waits();
    int pen_cycles = 0;
    tick();
    addr_a[2] = 32'h0000_0040; wdata_a[2] = 32'hCAFE_0001; wr_a = 4'b0100; drive_payload();
    pready_i = 1'b0; prdata_i = 32'hFFFF_FFFF; req_i = 4'b0100;
    @(negedge clk);
    chk_cnt++;
    if (gnt_o !== 4'b0100) $display("FAIL wr_gnt got %b need 0100", gnt_o);
    else pass_cnt++;
    tick(); req_i = '0;
    @(negedge clk);
    chk_cnt++;
    if ({psel_o, penable_o} !== 2'b10 || paddr_o !== 32'h0000_0040)
      $display("FAIL wr_setup got psel/pen=%b%b paddr=%h", psel_o, penable_o, paddr_o);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      tick(); pready_i = (i == 3);
      @(negedge clk);
      if (penable_o === 1'b1) pen_cycles++;
      chk_cnt++;
      if (psel_o !== 1'b1 || done_o !== '0 || paddr_o !== 32'h0000_0040 ||
          pwdata_o !== 32'hCAFE_0001 || pwrite_o !== 1'b1)
        $display("FAIL wr_wait%0d got psel=%b done=%b paddr=%h pwdata=%h pwrite=%b",
                 i, psel_o, done_o, paddr_o, pwdata_o, pwrite_o);
      else pass_cnt++;
    end
    chk_cnt++;
    if (pen_cycles !== 4) $display("FAIL wr_pen_len got %0d cycles need 4", pen_cycles);
    else pass_cnt++;
    tick(); pready_i = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (done_o !== 4'b0100 || err_o !== 1'b0 || rdata_o !== 32'h0000_1234 || psel_o !== 1'b0)
      $display("FAIL wr_done got done=%b err=%b rdata=%h psel=%b, need 0100 0 00001234 0",
               done_o, err_o, rdata_o, psel_o);
    else pass_cnt++;
    tick();
    @(negedge clk);
    chk_cnt++;
    if (done_o !== '0 || psel_o !== 1'b0)
      $display("FAIL wr_single_done got done=%b psel=%b need 0000 0", done_o, psel_o);
    else pass_cnt++;
  endtask

  task automatic test_fairness();
    logic [NUM_REQ-1:0] exp;
    do_reset();
    for (int k = 0; k < NUM_REQ; k++) begin
      addr_a[k] = 32'h0000_1000 + k; wdata_a[k] = $urandom; wr_a[k] = 1'($urandom);
    end
    drive_payload();
    pready_i = 1'b1; req_i = 4'b1111;
    for (int i = 0; i < 15; i++) begin
      exp = '0;
      if (i % 3 == 0) exp[(i / 3) % NUM_REQ] = 1'b1;
      @(negedge clk);
      chk_cnt++;
      if (gnt_o !== exp) $display("FAIL fair_gnt cyc=%0d got %b need %b", i, gnt_o, exp);
      else pass_cnt++;
      if (i % 3 == 1) begin
        chk_cnt++;
        if (paddr_o !== 32'h0000_1000 + (i / 3) % NUM_REQ)
          $display("FAIL fair_paddr cyc=%0d got %h need %h", i, paddr_o, 32'h0000_1000 + (i / 3) % NUM_REQ);
        else pass_cnt++;
      end
      tick();
    end
  endtask

  task automatic test_two_competitors();
    logic [NUM_REQ-1:0] exp;
    do_reset();
    pready_i = 1'b1; req_i = 4'b0110;
    for (int i = 0; i < 12; i++) begin
      exp = '0;
      if (i % 3 == 0) exp[((i / 3) % 2 == 0) ? 1 : 2] = 1'b1;
      @(negedge clk);
      chk_cnt++;
      if (gnt_o !== exp) $display("FAIL two_gnt cyc=%0d got %b need %b", i, gnt_o, exp);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    pready_i = 1'b0; req_i = 4'b0001;
    @(negedge clk);
    chk_cnt++;
    if (gnt_o !== 4'b0001) $display("FAIL rst_mid_gnt got %b need 0001", gnt_o);
    else pass_cnt++;
    tick(); req_i = '0;
    tick();
    @(negedge clk);
    chk_cnt++;
    if (penable_o !== 1'b1) $display("FAIL rst_mid_access got pen=%b need 1", penable_o);
    else pass_cnt++;
    tick();
    #1 reset = 1'b1;
    #1;
    chk_cnt++;
    if ({psel_o, penable_o, done_o} !== '0)
      $display("FAIL rst_mid_async got psel=%b pen=%b done=%b need 0", psel_o, penable_o, done_o);
    else pass_cnt++;
    tick();
    tick();
    reset = 1'b0; pready_i = 1'b1; req_i = 4'b1111;
    @(negedge clk);
    chk_cnt++;
    if (gnt_o !== 4'b0001 || done_o !== '0)
      $display("FAIL rst_mid_regrant got gnt=%b done=%b need 0001 0000", gnt_o, done_o);
    else pass_cnt++;
    tick(); req_i = '0;
  endtask

  task automatic test_timeout();
    int acc_cycles = 0;
    do_reset();
    addr_a[0] = 32'h0000_0100; wr_a = 4'b0000; drive_payload();
    pready_i = 1'b0; prdata_i = 32'h5A5A_5A5A; req_i = 4'b0001;
    @(negedge clk);
    chk_cnt++;
    if (gnt_o !== 4'b0001) $display("FAIL to_gnt got %b need 0001", gnt_o);
    else pass_cnt++;
    tick();
    addr_a[1] = 32'h0000_0200; wr_a = 4'b0010; drive_payload(); req_i = 4'b0010;
`ifdef APB_ARB_TIMEOUT_EN
    for (int i = 0; i < TO_CYC; i++) begin
      tick();
      @(negedge clk);
      if (psel_o === 1'b1 && penable_o === 1'b1 && done_o === '0) acc_cycles++;
    end
    chk_cnt++;
    if (acc_cycles !== TO_CYC) $display("FAIL to_access_len got %0d need %0d", acc_cycles, TO_CYC);
    else pass_cnt++;
    tick();
    @(negedge clk);
    chk_cnt++;
    if (done_o !== 4'b0001 || err_o !== 1'b1 || psel_o !== 1'b0 || rdata_o !== '0)
      $display("FAIL to_abort got done=%b err=%b psel=%b rdata=%h need 0001 1 0 0",
               done_o, err_o, psel_o, rdata_o);
    else pass_cnt++;
    chk_cnt++;
    if (gnt_o !== 4'b0010) $display("FAIL to_next_gnt got %b need 0010", gnt_o);
    else pass_cnt++;
    tick(); req_i = '0;
    tick(); pready_i = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (penable_o !== 1'b1 || paddr_o !== 32'h0000_0200)
      $display("FAIL to_next_access got pen=%b paddr=%h", penable_o, paddr_o);
    else pass_cnt++;
    tick();
    @(negedge clk);
    chk_cnt++;
    if (done_o !== 4'b0010 || err_o !== 1'b0)
      $display("FAIL to_next_done got done=%b err=%b need 0010 0", done_o, err_o);
    else pass_cnt++;
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      @(negedge clk);
      if (psel_o === 1'b1 && penable_o === 1'b1 && done_o === '0 && err_o === 1'b0) acc_cycles++;
    end
    chk_cnt++;
    if (acc_cycles !== 100) $display("FAIL to_wait_forever got %0d access cycles need 100", acc_cycles);
    else pass_cnt++;
    tick(); pready_i = 1'b1;
    tick();
    @(negedge clk);
    chk_cnt++;
    if (done_o !== 4'b0001 || err_o !== 1'b0)
      $display("FAIL to_late_done got done=%b err=%b need 0001 0", done_o, err_o);
    else pass_cnt++;
`endif
    tick(); req_i = '0;
  endtask

  // Transaction-level model: the bench chooses each transfer's wait count and derives
  // every expected output cycle from the grant cycle and that count.
  task automatic test_random(input int ncyc);
    logic [NUM_REQ-1:0] pend, exp_gnt, exp_done;
    logic [ADDR_W-1:0]  c_addr;
    logic [DATA_W-1:0]  c_wdata, exp_rdata, rd_hold;
    logic               c_write, exp_psel, exp_pen;
    bit                 active, any_xfer;
    int                 st, wt, ow, last, w;
    pend = '0; active = 0; any_xfer = 0; st = 0; wt = 0; ow = 0; last = NUM_REQ - 1;
    c_addr = '0; c_wdata = '0; c_write = 1'b0; exp_rdata = '0; rd_hold = '0;
    do_reset();
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      if (cyc != 0) tick();
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!pend[k]) begin
          addr_a[k] = $urandom; wdata_a[k] = $urandom; wr_a[k] = 1'($urandom);
          if ($urandom_range(0, 3) == 0) pend[k] = 1'b1;
        end else if ($urandom_range(0, 19) == 0) pend[k] = 1'b0;
      end
      req_i = pend;
      drive_payload();
      prdata_i = $urandom;
      exp_done = '0;
      if (active && cyc == st + 3 + wt) begin
        exp_done[ow] = 1'b1;
        active = 0;
        if (!c_write) exp_rdata = rd_hold;
      end
      if (active && cyc == st + 2 + wt) begin
        pready_i = 1'b1;
        rd_hold  = prdata_i;
      end else if (active && cyc >= st + 2) pready_i = 1'b0;
      else pready_i = 1'($urandom);
      exp_gnt = '0;
      if (!active && req_i != '0) begin
        w = -1;
        for (int o = 1; o <= NUM_REQ; o++) begin
          if (w < 0 && req_i[(last + o) % NUM_REQ]) w = (last + o) % NUM_REQ;
        end
        exp_gnt[w] = 1'b1;
        active = 1; any_xfer = 1; st = cyc; wt = $urandom_range(0, 3); ow = w; last = w;
        c_addr = addr_a[w]; c_wdata = wdata_a[w]; c_write = wr_a[w];
        pend[w] = 1'b0;
      end
      exp_psel = active && cyc > st;
      exp_pen  = active && cyc >= st + 2;
      @(negedge clk);
      chk_cnt++;
      if (gnt_o !== exp_gnt) $display("FAIL rnd_gnt cyc=%0d got %b need %b", cyc, gnt_o, exp_gnt);
      else pass_cnt++;
      chk_cnt++;
      if (done_o !== exp_done || err_o !== 1'b0)
        $display("FAIL rnd_done cyc=%0d got %b/%b need %b/0", cyc, done_o, err_o, exp_done);
      else pass_cnt++;
      chk_cnt++;
      if (psel_o !== exp_psel || penable_o !== exp_pen)
        $display("FAIL rnd_bus cyc=%0d got psel/pen=%b%b need %b%b", cyc, psel_o, penable_o, exp_psel, exp_pen);
      else pass_cnt++;
      chk_cnt++;
      if (rdata_o !== exp_rdata) $display("FAIL rnd_rdata cyc=%0d got %h need %h", cyc, rdata_o, exp_rdata);
      else pass_cnt++;
      if (exp_psel || (!active && any_xfer)) begin
        chk_cnt++;
        if (paddr_o !== c_addr || pwrite_o !== c_write || pwdata_o !== c_wdata)
          $display("FAIL rnd_payload cyc=%0d got %h/%b/%h need %h/%b/%h", cyc,
                   paddr_o, pwrite_o, pwdata_o, c_addr, c_write, c_wdata);
        else pass_cnt++;
      end
    end
    tick();
    req_i = '0;
  endtask

  initial begin
    reset = 1'b1;
    req_i = '0; req_write_i = '0; req_addr_i = '0; req_wdata_i = '0;
    pready_i = 1'b0; prdata_i = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      addr_a[k] = '0; wdata_a[k] = '0;
    end
    wr_a = '0;
    test_reset();
    test_read_zero_wait();
    test_write_waits();
    test_fairness();
    test_two_competitors();
    test_reset_mid_access();
    test_timeout();
    test_random(400);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
